// File: rtl/kevin_pkg.sv
// Shared types and constants for the Kevin number generator.
package kevin_pkg;

    localparam int unsigned VAL_W      = 4;
    localparam logic [15:0] KEVIN_MASK = 16'h56E2;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StEmit,
        StDone
    } state_e;

endpackage

// File: rtl/kevin_member.sv
// Combinational membership test: is idx in the (optionally inverted) mask set.
module kevin_member
    import kevin_pkg::*;
(
    input  logic [VAL_W-1:0] idx,
    input  logic [15:0]      mask,
    input  logic             inv,
    output logic             hit
);

    assign hit = mask[idx] ^ inv;

endmodule

// File: rtl/kevin_gen.sv
// Enumerates 0..15 and streams every value in the (optionally inverted) mask set
// over a valid/ready interface, reporting the emitted count and a done pulse.
module kevin_gen
    import kevin_pkg::*;
#(
    parameter logic [15:0] MASK = KEVIN_MASK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             invert,
    input  logic             abort,
    output logic [VAL_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic [4:0]       count
);

    state_e           state_q, state_d;
    logic [VAL_W-1:0] idx_q, idx_d;
    logic             inv_q, inv_d;
    logic [VAL_W-1:0] data_d;
    logic             valid_d;
    logic             busy_d;
    logic             done_d;
    logic [4:0]       count_d;
    logic             hit;

    kevin_member u_member (
        .idx  (idx_q),
        .mask (MASK),
        .inv  (inv_q),
        .hit  (hit)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        inv_d   = inv_q;
        data_d  = out_data;
        valid_d = out_valid;
        count_d = count;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    inv_d   = invert;
                    idx_d   = '0;
                    count_d = '0;
                    state_d = StScan;
                end
            end
            StScan: begin
                if (hit) begin
                    data_d  = idx_q;
                    valid_d = 1'b1;
                    state_d = StEmit;
                end else if (idx_q == 4'd15) begin
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            StEmit: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    count_d = count + 5'd1;
                    if (idx_q == 4'd15) begin
                        state_d = StDone;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = StScan;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Abort overrides any handshake; count keeps its partial value.
        if (abort && (state_q != StIdle)) begin
            state_d = StIdle;
            idx_d   = idx_q;
            valid_d = 1'b0;
            count_d = count;
        end

        done_d = (state_d == StDone);
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            inv_q     <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            count     <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            inv_q     <= inv_d;
            out_data  <= data_d;
            out_valid <= valid_d;
            busy      <= busy_d;
            done      <= done_d;
            count     <= count_d;
        end
    end

endmodule

// File: tb/tb_kevin_gen.sv
// Scoreboard bench for kevin_gen: default, empty and full mask instances.
module tb_kevin_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_d = 1'b0, start_z = 1'b0, start_f = 1'b0;
    logic       invert = 1'b0;
    logic       abort = 1'b0;
    logic       out_ready = 1'b1;

    logic [3:0] d_data, z_data, f_data;
    logic       d_valid, z_valid, f_valid;
    logic       d_busy, z_busy, f_busy;
    logic       d_done, z_done, f_done;
    logic [4:0] d_count, z_count, f_count;

    int errors = 0;
    int checks = 0;
    int sb[$];

    int kevin_vals[8] = '{1, 5, 6, 7, 9, 10, 12, 14};

    always #5 clk = ~clk;

    kevin_gen u_dut_d (
        .clk(clk), .rst(rst), .start(start_d), .invert(invert), .abort(abort),
        .out_data(d_data), .out_valid(d_valid), .out_ready(out_ready),
        .busy(d_busy), .done(d_done), .count(d_count)
    );

    kevin_gen #(.MASK(16'h0000)) u_dut_z (
        .clk(clk), .rst(rst), .start(start_z), .invert(invert), .abort(abort),
        .out_data(z_data), .out_valid(z_valid), .out_ready(out_ready),
        .busy(z_busy), .done(z_done), .count(z_count)
    );

    kevin_gen #(.MASK(16'hFFFF)) u_dut_f (
        .clk(clk), .rst(rst), .start(start_f), .invert(invert), .abort(abort),
        .out_data(f_data), .out_valid(f_valid), .out_ready(out_ready),
        .busy(f_busy), .done(f_done), .count(f_count)
    );

    // Stream monitor for the default instance, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst && d_valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL stream_extra: got %0d, required no value", d_data);
            end else begin
                if (d_data !== 4'(sb[0])) begin
                    errors++;
                    $display("FAIL stream_data: got %0d, required %0d", d_data, sb[0]);
                end
                if (out_ready && !abort) void'(sb.pop_front());
            end
        end
    end

    task automatic push_expected(input logic inv);
        for (int v = 0; v < 16; v++) begin
            bit member = 1'b0;
            for (int k = 0; k < 8; k++) if (kevin_vals[k] == v) member = 1'b1;
            if (member ^ inv) sb.push_back(v);
        end
    endtask

    task automatic check_sb_empty(input string name);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d values never emitted, required 0", name, sb.size());
        end
        sb.delete();
    endtask

    task automatic run_stream(input logic inv, input bit bp, input bit poke,
                              output int done_cyc, output int first_cyc, output int pulses);
        int stall = 0;
        done_cyc  = -1;
        first_cyc = -1;
        pulses    = 0;
        push_expected(inv);
        @(posedge clk); #1;
        invert = inv; start_d = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        start_d = 1'b0; invert = 1'b0;
        for (int cyc = 1; cyc <= 300; cyc++) begin
            @(posedge clk); #1;
            if (d_valid && first_cyc < 0) first_cyc = cyc;
            if (d_done) begin
                pulses++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (bp) begin
                if (!d_valid) stall = 0;
                out_ready = !(d_valid && stall < 3);
                if (d_valid && stall < 3) stall++;
            end
            start_d = poke && (cyc == 5);
            invert  = (poke && cyc == 5) ? ~inv : 1'b0;
            if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
        end
        out_ready = 1'b1;
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if ({d_data, d_valid, d_busy, d_done, d_count} !== 12'd0) begin
            errors++;
            $display("FAIL reset_d: got %h, required 0", {d_data, d_valid, d_busy, d_done, d_count});
        end
        checks++;
        if ({z_valid, z_busy, z_done, z_count, f_valid, f_busy, f_done, f_count} !== 16'd0) begin
            errors++;
            $display("FAIL reset_zf: got %h, required 0",
                     {z_valid, z_busy, z_done, z_count, f_valid, f_busy, f_done, f_count});
        end
        @(negedge clk); rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (d_busy !== 1'b0 || d_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b valid=%b, required 0 0", d_busy, d_valid);
        end
    endtask

    task automatic check_run(input string name, input int done_cyc, input int exp_done,
                             input int first_cyc, input int exp_first, input int pulses);
        checks++;
        if (done_cyc != exp_done) begin
            errors++;
            $display("FAIL %s_done_cycle: got %0d, required %0d", name, done_cyc, exp_done);
        end
        checks++;
        if (first_cyc != exp_first) begin
            errors++;
            $display("FAIL %s_first_valid: got %0d, required %0d", name, first_cyc, exp_first);
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL %s_done_pulses: got %0d, required 1", name, pulses);
        end
        checks++;
        if (d_count !== 5'd8) begin
            errors++;
            $display("FAIL %s_count: got %0d, required 8", name, d_count);
        end
        checks++;
        if (d_busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_busy_after: got %b, required 0", name, d_busy);
        end
        check_sb_empty({name, "_drain"});
    endtask

    task automatic test_default;
        int dc, fc, p;
        run_stream(1'b0, 1'b0, 1'b0, dc, fc, p);
        check_run("default", dc, 24, fc, 2, p);
    endtask

    task automatic test_invert;
        int dc, fc, p;
        run_stream(1'b1, 1'b0, 1'b0, dc, fc, p);
        check_run("invert", dc, 24, fc, 1, p);
    endtask

    task automatic test_backpressure;
        int dc, fc, p;
        run_stream(1'b0, 1'b1, 1'b0, dc, fc, p);
        check_run("backpressure", dc, 48, fc, 2, p);
    endtask

    task automatic test_start_ignored;
        int dc, fc, p;
        run_stream(1'b0, 1'b0, 1'b1, dc, fc, p);
        check_run("start_ignored", dc, 24, fc, 2, p);
    endtask

    task automatic test_abort;
        int dc, fc, p;
        bit found = 1'b0;
        int stray = 0;
        push_expected(1'b0);
        @(posedge clk); #1; start_d = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1; start_d = 1'b0;
        for (int cyc = 0; cyc < 60 && !found; cyc++) begin
            @(posedge clk); #1;
            if (d_valid && d_data == 4'd7) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL abort_reach7: value 7 not seen within 60 cycles, required seen");
        end
        out_ready = 1'b0;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0; out_ready = 1'b1;
        checks++;
        if ({d_valid, d_busy, d_done} !== 3'b000) begin
            errors++;
            $display("FAIL abort_outputs: valid/busy/done=%b, required 000",
                     {d_valid, d_busy, d_done});
        end
        checks++;
        if (d_count !== 5'd3) begin
            errors++;
            $display("FAIL abort_count: got %0d, required 3", d_count);
        end
        sb.delete();
        repeat (4) begin
            @(posedge clk); #1;
            if (d_done || d_busy || d_valid) stray++;
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL abort_quiet: %0d active cycles after abort, required 0", stray);
        end
        run_stream(1'b0, 1'b0, 1'b0, dc, fc, p);
        check_run("abort_rerun", dc, 24, fc, 2, p);
    endtask

    task automatic test_reset_midrun;
        bit found = 1'b0;
        push_expected(1'b0);
        @(posedge clk); #1; start_d = 1'b1;
        @(posedge clk); #1; start_d = 1'b0;
        for (int cyc = 0; cyc < 60 && !found; cyc++) begin
            @(posedge clk); #1;
            if (d_valid && d_data == 4'd5) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL rstmid_reach5: value 5 not seen within 60 cycles, required seen");
        end
        #1; rst = 1'b1;
        #1;
        checks++;
        if ({d_data, d_valid, d_busy, d_done, d_count} !== 12'd0) begin
            errors++;
            $display("FAIL rstmid_async: got %h, required 0", {d_data, d_valid, d_busy, d_done, d_count});
        end
        sb.delete();
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_empty;
        int done_cyc = -1;
        int valids = 0;
        @(posedge clk); #1; start_z = 1'b1;
        @(posedge clk); #1; start_z = 1'b0;
        for (int cyc = 1; cyc <= 40 && done_cyc < 0; cyc++) begin
            @(posedge clk); #1;
            if (z_valid) valids++;
            if (z_done) done_cyc = cyc;
        end
        checks++;
        if (done_cyc != 16) begin
            errors++;
            $display("FAIL empty_done_cycle: got %0d, required 16", done_cyc);
        end
        checks++;
        if (valids != 0 || z_count !== 5'd0) begin
            errors++;
            $display("FAIL empty_output: valids=%0d count=%0d, required 0 0", valids, z_count);
        end
    endtask

    task automatic test_full;
        int done_cyc = -1;
        int exp_v = 0;
        out_ready = 1'b1;
        @(posedge clk); #1; start_f = 1'b1;
        @(posedge clk); #1; start_f = 1'b0;
        for (int cyc = 1; cyc <= 60 && done_cyc < 0; cyc++) begin
            @(posedge clk); #1;
            if (f_valid) begin
                checks++;
                if (f_data !== 4'(exp_v)) begin
                    errors++;
                    $display("FAIL full_data: got %0d, required %0d", f_data, exp_v);
                end
                exp_v++;
            end
            if (f_done) done_cyc = cyc;
        end
        checks++;
        if (done_cyc != 32 || exp_v != 16) begin
            errors++;
            $display("FAIL full_run: done_cycle=%0d values=%0d, required 32 16", done_cyc, exp_v);
        end
        checks++;
        if (f_count !== 5'd16) begin
            errors++;
            $display("FAIL full_count: got %0d, required 16", f_count);
        end
    endtask

    initial begin
        test_reset();
        test_default();
        test_invert();
        test_backpressure();
        test_abort();
        test_start_ignored();
        test_reset_midrun();
        test_default();
        test_empty();
        test_full();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
